// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM duty-ramp sequencer.
package pwm_pkg;

  localparam logic [5:0] ADDR_CMP1_L    = 6'h06;
  localparam logic [5:0] ADDR_CMP1_H    = 6'h07;
  localparam logic [5:0] ADDR_RAMP_STAT = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LO,
    ST_WR_HI,
    ST_WAIT,
    ST_DONE
  } ramp_state_t;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Byte-wide register bus. instr_dcd is the master on the host side; this
// block is the master towards regs.
interface pwm_ramp_ctrl_if;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;

  modport master (output read, write, addr, data_write, input data_read);
  modport slave  (input read, write, addr, data_write, output data_read);
endinterface

// File: rtl/pwm_ramp_ctrl_period_tick.sv
// Registered zero-crossing detector: one-cycle pulse the cycle after
// counter_val lands on 0 coming from a non-zero value, in either count direction.
module period_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] counter_val,
  output logic         tick
);

  logic prev_nz;

  // Remember last cycle's non-zero status and raise tick on the 1->0 transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_nz <= 1'b0;
      tick    <= 1'b0;
    end else begin
      prev_nz <= |counter_val;
      tick    <= (counter_val == '0) && prev_nz;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Register-bus arbiter + compare1 duty-ramp sequencer between instr_dcd and regs.
// Host accesses always win and pass through combinationally; the ramp engine
// writes compare1 (LO then HI byte) only in host-idle cycles.
// Optional feature: define PWM_RAMP_STATUS_EN to add a status register at
// ADDR_RAMP_STAT ({6'b0, done_sticky, ramp_busy}) answered locally.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int RAMP_W = 16,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_ramp_ctrl_if.slave    host,
  pwm_ramp_ctrl_if.master   regs,
  input  logic [RAMP_W-1:0] counter_val,
  input  logic [RAMP_W-1:0] period,
  input  logic              ramp_start,
  input  logic              ramp_abort,
  input  logic [RAMP_W-1:0] ramp_from,
  input  logic [RAMP_W-1:0] ramp_target,
  input  logic [RAMP_W-1:0] ramp_step,
  input  logic [DIV_W-1:0]  ramp_div,
  output logic              ramp_busy,
  output logic              ramp_done
);

  ramp_state_t       state, state_nx;
  logic [RAMP_W-1:0] cur, cur_nx, tgt, stp, step_val;
  logic [DIV_W-1:0]  div, divcnt, divcnt_nx;
  logic              abort_pend, abort_nx;
  logic              load, tick, host_busy;
  logic              eng_wr;
  logic [5:0]        eng_addr;
  logic [7:0]        eng_data;
  logic [RAMP_W:0]   up_sum, dn_diff;

  // period is part of the bus bundle but the ramp only needs the zero crossing
  logic unused_period;
  assign unused_period = ^period;

  assign host_busy = host.read | host.write;
  assign ramp_busy = (state != ST_IDLE);

  period_tick #(.W(RAMP_W)) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .counter_val (counter_val),
    .tick        (tick)
  );

  // One extra bit so overshoot past either end of the range is visible
  assign up_sum  = {1'b0, cur} + {1'b0, stp};
  assign dn_diff = {1'b0, cur} - {1'b0, stp};

  // Next ramp value: move toward target by step, clamp exactly at target
  always_comb begin
    step_val = tgt;
    if (stp != '0 && cur != tgt) begin
      if (tgt > cur)
        step_val = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[RAMP_W-1:0];
      else
        step_val = (dn_diff[RAMP_W] || dn_diff[RAMP_W-1:0] <= tgt) ? tgt : dn_diff[RAMP_W-1:0];
    end
  end

  // FSM next-state, engine write request and done pulse
  always_comb begin
    state_nx  = state;
    cur_nx    = cur;
    divcnt_nx = divcnt;
    abort_nx  = abort_pend;
    load      = 1'b0;
    eng_wr    = 1'b0;
    eng_addr  = '0;
    eng_data  = '0;
    ramp_done = 1'b0;
    case (state)
      ST_IDLE: begin
        abort_nx = 1'b0;
        if (!ramp_abort && ramp_start) begin
          load     = 1'b1;
          cur_nx   = ramp_from;
          state_nx = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        if (!host_busy) begin
          eng_wr   = 1'b1;
          eng_addr = ADDR_CMP1_L;
          eng_data = cur[7:0];
          state_nx = ST_WR_HI;
          // LO byte is already on the bus: finish the HI byte before stopping
          if (ramp_abort) abort_nx = 1'b1;
        end else if (ramp_abort) begin
          state_nx = ST_IDLE;
        end
      end
      ST_WR_HI: begin
        abort_nx = abort_pend | ramp_abort;
        if (!host_busy) begin
          eng_wr   = 1'b1;
          eng_addr = ADDR_CMP1_H;
          eng_data = cur[15:8];
          if (abort_pend || ramp_abort) begin
            state_nx = ST_IDLE;
            abort_nx = 1'b0;
          end else if (cur == tgt) begin
            state_nx = ST_DONE;
          end else begin
            state_nx  = ST_WAIT;
            divcnt_nx = div;
          end
        end
      end
      ST_WAIT: begin
        if (ramp_abort) begin
          state_nx = ST_IDLE;
        end else if (tick) begin
          if (divcnt == '0) begin
            cur_nx   = step_val;
            state_nx = ST_WR_LO;
          end else begin
            divcnt_nx = divcnt - DIV_W'(1);
          end
        end
      end
      ST_DONE: begin
        ramp_done = !ramp_abort;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM state and ramp working registers; parameters latched on accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur        <= '0;
      tgt        <= '0;
      stp        <= '0;
      div        <= '0;
      divcnt     <= '0;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      cur        <= cur_nx;
      divcnt     <= divcnt_nx;
      abort_pend <= abort_nx;
      if (load) begin
        tgt <= ramp_target;
        stp <= ramp_step;
        div <= ramp_div;
      end
    end
  end

`ifdef PWM_RAMP_STATUS_EN
  logic stat_hit, done_sticky;
  assign stat_hit = (host.addr == ADDR_RAMP_STAT);

  // Sticky completion flag; a new completion beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      done_sticky <= 1'b0;
    else if (ramp_done)
      done_sticky <= 1'b1;
    else if (host.write && stat_hit)
      done_sticky <= 1'b0;
  end

  // Status reads are answered here; everything else comes from regs
  always_comb begin
    host.data_read = regs.data_read;
    if (host.read && stat_hit) host.data_read = {6'b0, done_sticky, ramp_busy};
  end
`else
  assign host.data_read = regs.data_read;
`endif

  // Bus mux: host has strict priority, engine fills idle cycles
  always_comb begin
    regs.read       = 1'b0;
    regs.write      = eng_wr;
    regs.addr       = eng_addr;
    regs.data_write = eng_data;
    if (host_busy) begin
      regs.read       = host.read;
      regs.write      = host.write;
      regs.addr       = host.addr;
      regs.data_write = host.data_write;
`ifdef PWM_RAMP_STATUS_EN
      if (stat_hit) begin
        regs.read  = 1'b0;
        regs.write = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: expected compare1 byte writes are generated from
// the ramp rules with plain integer arithmetic and checked every cycle.
module tb_pwm_ramp_ctrl;
  import pwm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_ramp_ctrl_if hb ();
  pwm_ramp_ctrl_if rb ();

  logic [15:0] counter_val, period, ramp_from, ramp_target, ramp_step;
  logic [7:0]  ramp_div;
  logic        ramp_start, ramp_abort, ramp_busy, ramp_done;

  pwm_ramp_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (hb),
    .regs        (rb),
    .counter_val (counter_val),
    .period      (period),
    .ramp_start  (ramp_start),
    .ramp_abort  (ramp_abort),
    .ramp_from   (ramp_from),
    .ramp_target (ramp_target),
    .ramp_step   (ramp_step),
    .ramp_div    (ramp_div),
    .ramp_busy   (ramp_busy),
    .ramp_done   (ramp_done)
  );

  typedef logic [7:0] lit8_t [8];

  int total = 0, bad = 0, cyc = 0, t0 = 0;
  int done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, last_zero = 0;
  bit cnt_en = 1'b1;
  logic [13:0] exp_q [$];
  logic [7:0]  wlog [$];
  int          lo_cyc [$];
  int          lo_gap [$];
  lit8_t       lit;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Free-running down counter, period 8 cycles
  initial begin
    counter_val = 16'd7;
    period      = 16'd7;
    forever begin
      @(posedge clk); #1;
      if (cnt_en) counter_val = (counter_val == 16'd0) ? 16'd7 : counter_val - 16'd1;
    end
  end

  // Compare process: bus passthrough, engine writes against the model queue
  always @(negedge clk) begin
    logic stat;
    logic [13:0] e;
    if (rst_n) begin
      if (counter_val == 16'd0) last_zero = cyc;
      if (hb.read | hb.write) begin
`ifdef PWM_RAMP_STATUS_EN
        stat = (hb.addr == 6'h3F);
`else
        stat = 1'b0;
`endif
        chk("pass_read", rb.read, hb.read & ~stat);
        chk("pass_write", rb.write, hb.write & ~stat);
        if (!stat) begin
          chk("pass_addr", rb.addr, hb.addr);
          chk("pass_wdata", rb.data_write, hb.data_write);
          chk("pass_rdata", hb.data_read, rb.data_read);
        end
      end else begin
        chk("eng_no_read", rb.read, 1'b0);
        chk("idle_rdata", hb.data_read, rb.data_read);
        if (rb.write) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_wr: actual addr=%0h data=%0h required no write", rb.addr, rb.data_write);
          end else begin
            e = exp_q.pop_front();
            chk("eng_wr", {rb.addr, rb.data_write}, e);
          end
          wlog.push_back(rb.data_write);
          last_wr_cyc = cyc;
          if (rb.addr == 6'h06) begin
            lo_cyc.push_back(cyc);
            lo_gap.push_back(cyc - last_zero);
          end
        end
      end
      if (ramp_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Reference ramp: byte writes LO/HI for every value from start to target
  task automatic push_pair(int c);
    exp_q.push_back({6'h06, c[7:0]});
    exp_q.push_back({6'h07, c[15:8]});
  endtask

  task automatic model_ramp(int from, int tgt, int step);
    int c = from;
    while (1) begin
      push_pair(c);
      if (c == tgt) break;
      if (step == 0)      c = tgt;
      else if (tgt > c)   c = (c + step > tgt) ? tgt : c + step;
      else                c = (c - step < tgt) ? tgt : c - step;
    end
  endtask

  task automatic tick1();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    wlog.delete(); lo_cyc.delete(); lo_gap.delete(); exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_ramp(logic [15:0] f, logic [15:0] t, logic [15:0] s, logic [7:0] d);
    tick1();
    ramp_from = f; ramp_target = t; ramp_step = s; ramp_div = d;
    ramp_start = 1'b1; t0 = cyc;
    tick1();
    ramp_start = 1'b0;
  endtask

  task automatic wait_idle(int maxc, string name);
    int n = 0;
    while (n < maxc) begin
      @(negedge clk);
      if (!ramp_busy) break;
      n++;
    end
    total++;
    if (n >= maxc) begin
      bad++;
      $display("FAIL %s_timeout: actual busy after %0d cycles required idle", name, n);
    end
  endtask

  task automatic chk_log(string name, lit8_t l, int n);
    chk({name, "_len"}, wlog.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", name, i), (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF, 32'(l[i]));
  endtask

  task automatic run_ramp(string name, logic [15:0] f, logic [15:0] t, logic [15:0] s, lit8_t l, int n);
    clear_logs();
    model_ramp(f, t, s);
    start_ramp(f, t, s, 8'd0);
    wait_idle(600, name);
    chk_log(name, l, n);
    chk({name, "_done"}, done_cnt, 1);
    chk({name, "_qempty"}, exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hb.read = 1'b0; hb.write = 1'b0; hb.addr = '0; hb.data_write = '0;
    rb.data_read = 8'h3C;
    ramp_start = 1'b0; ramp_abort = 1'b0;
    ramp_from = '0; ramp_target = '0; ramp_step = '0; ramp_div = '0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_write", rb.write, 1'b0);
    chk("rst_read", rb.read, 1'b0);
    chk("rst_addr", rb.addr, 6'h00);
    chk("rst_wdata", rb.data_write, 8'h00);
    chk("rst_busy", ramp_busy, 1'b0);
    chk("rst_done", ramp_done, 1'b0);
    chk("rst_rdata", hb.data_read, 8'h3C);
    tick1(); rst_n = 1'b1;
    repeat (3) tick1();

    // basic up-ramp, div=0, with latency checks
    clear_logs();
    model_ramp(16'h0010, 16'h0040, 16'h0010);
    start_ramp(16'h0010, 16'h0040, 16'h0010, 8'd0);
    @(negedge clk);
    chk("t1_lo_first", {rb.write, rb.addr, rb.data_write}, {1'b1, 6'h06, 8'h10});
    chk("t1_busy", ramp_busy, 1'b1);
    @(negedge clk);
    chk("t1_hi_first", {rb.write, rb.addr, rb.data_write}, {1'b1, 6'h07, 8'h00});
    wait_idle(300, "t1");
    lit = '{8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40, 8'h00};
    chk_log("t1_log", lit, 8);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_lat", done_cyc, last_wr_cyc + 1);
    for (int i = 2; i < 4; i++)
      chk("t1_period", (lo_cyc.size() > i) ? lo_cyc[i] - lo_cyc[i-1] : -1, 8);
    for (int i = 1; i < 4; i++)
      chk("t1_tick_lat", (lo_gap.size() > i) ? lo_gap[i] : -1, 2);
    chk("t1_qempty", exp_q.size(), 0);

    // saturation, down-ramp, from==target, step==0
    lit = '{8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    run_ramp("t2_sat_up", 16'hFFF0, 16'hFFFF, 16'h0020, lit, 4);
    lit = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_ramp("t3_sat_dn", 16'h0005, 16'h0000, 16'h0008, lit, 4);
    lit = '{8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_ramp("t4_equal", 16'h1234, 16'h1234, 16'h0003, lit, 2);
    lit = '{8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    run_ramp("t5_step0", 16'h0100, 16'h0300, 16'h0000, lit, 4);

    // host priority over a pending LO write
    clear_logs();
    model_ramp(16'h0050, 16'h0050, 16'h0007);
    start_ramp(16'h0050, 16'h0050, 16'h0007, 8'd0);
    hb.write = 1'b1; hb.addr = 6'h10; hb.data_write = 8'hA1;
    tick1(); hb.addr = 6'h11; hb.data_write = 8'hA2;
    tick1(); hb.addr = 6'h12; hb.data_write = 8'hA3;
    tick1(); hb.write = 1'b0;
    @(negedge clk);
    chk("t6_lo_delayed", {rb.write, rb.addr, rb.data_write}, {1'b1, 6'h06, 8'h50});
    @(negedge clk);
    chk("t6_hi", {rb.write, rb.addr, rb.data_write}, {1'b1, 6'h07, 8'h00});
    wait_idle(100, "t6");
    lit = '{8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_log("t6_log", lit, 2);
    chk("t6_done", done_cnt, 1);
    tick1(); rb.data_read = 8'h5A; hb.read = 1'b1; hb.addr = 6'h05;
    @(negedge clk);
    chk("t6_rd_data", hb.data_read, 8'h5A);
    chk("t6_rd_fwd", rb.read, 1'b1);
    tick1(); hb.read = 1'b0;

    // abort in the LO-write cycle: HI still written, no done
    clear_logs();
    push_pair(16'h0010);
    start_ramp(16'h0010, 16'h0040, 16'h0010, 8'd0);
    ramp_abort = 1'b1;
    tick1(); ramp_abort = 1'b0;
    @(negedge clk);
    chk("t7_hi", {rb.write, rb.addr, rb.data_write}, {1'b1, 6'h07, 8'h00});
    @(negedge clk);
    chk("t7_busy", ramp_busy, 1'b0);
    repeat (30) tick1();
    lit = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_log("t7_log", lit, 2);
    chk("t7_done", done_cnt, 0);
    chk("t7_qempty", exp_q.size(), 0);

    // abort in WR_LO while host holds the bus: nothing written
    clear_logs();
    start_ramp(16'h0010, 16'h0040, 16'h0010, 8'd0);
    hb.write = 1'b1; hb.addr = 6'h20; hb.data_write = 8'h77; ramp_abort = 1'b1;
    tick1(); hb.write = 1'b0; ramp_abort = 1'b0;
    @(negedge clk);
    chk("t8_busy", ramp_busy, 1'b0);
    repeat (30) tick1();
    chk("t8_nwr", wlog.size(), 0);
    chk("t8_done", done_cnt, 0);

    // abort in WAIT (ticks frozen so the ramp is parked there)
    cnt_en = 1'b0;
    clear_logs();
    push_pair(16'h0010);
    start_ramp(16'h0010, 16'h0040, 16'h0010, 8'd0);
    repeat (3) tick1();
    ramp_abort = 1'b1;
    tick1(); ramp_abort = 1'b0;
    @(negedge clk);
    chk("t9_busy", ramp_busy, 1'b0);
    cnt_en = 1'b1;
    repeat (30) tick1();
    lit = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_log("t9_log", lit, 2);
    chk("t9_done", done_cnt, 0);

    // simultaneous start + abort in IDLE
    clear_logs();
    tick1();
    ramp_from = 16'h0020; ramp_target = 16'h0030; ramp_step = 16'h0001; ramp_div = 8'd0;
    ramp_start = 1'b1; ramp_abort = 1'b1;
    tick1(); ramp_start = 1'b0; ramp_abort = 1'b0;
    @(negedge clk);
    chk("t10_busy", ramp_busy, 1'b0);
    repeat (20) tick1();
    chk("t10_nwr", wlog.size(), 0);

    // divider=2 and a start while busy that must be ignored
    clear_logs();
    model_ramp(16'h0010, 16'h0030, 16'h0010);
    start_ramp(16'h0010, 16'h0030, 16'h0010, 8'd2);
    repeat (6) tick1();
    ramp_from = 16'h9999; ramp_target = 16'h1111; ramp_step = 16'h0001; ramp_div = 8'd0;
    ramp_start = 1'b1;
    tick1(); ramp_start = 1'b0;
    wait_idle(600, "t11");
    lit = '{8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00};
    chk_log("t11_log", lit, 6);
    chk("t11_period", (lo_cyc.size() > 2) ? lo_cyc[2] - lo_cyc[1] : -1, 24);
    for (int i = 1; i < 3; i++)
      chk("t11_tick_lat", (lo_gap.size() > i) ? lo_gap[i] : -1, 2);
    chk("t11_done", done_cnt, 1);
    chk("t11_qempty", exp_q.size(), 0);

    // status register reads / clear (forwarded when the feature is off)
    clear_logs();
    model_ramp(16'h0010, 16'h0030, 16'h0010);
    start_ramp(16'h0010, 16'h0030, 16'h0010, 8'd0);
    tick1(); tick1();
    rb.data_read = 8'hC3; hb.read = 1'b1; hb.addr = 6'h3F;
    @(negedge clk);
`ifdef PWM_RAMP_STATUS_EN
    chk("t12_stat_busy", hb.data_read, 8'h01);
    chk("t12_stat_nofwd", rb.read, 1'b0);
`else
    chk("t12_fwd_data", hb.data_read, 8'hC3);
    chk("t12_fwd_read", rb.read, 1'b1);
`endif
    tick1(); hb.read = 1'b0;
    wait_idle(300, "t12");
    chk("t12_done", done_cnt, 1);
    chk("t12_qempty", exp_q.size(), 0);
    tick1(); hb.read = 1'b1; hb.addr = 6'h3F;
    @(negedge clk);
`ifdef PWM_RAMP_STATUS_EN
    chk("t12_stat_done", hb.data_read, 8'h02);
`else
    chk("t12_fwd_data2", hb.data_read, 8'hC3);
`endif
    tick1(); hb.read = 1'b0; hb.write = 1'b1; hb.data_write = 8'hFF;
    tick1(); hb.write = 1'b0; hb.read = 1'b1;
    @(negedge clk);
`ifdef PWM_RAMP_STATUS_EN
    chk("t12_stat_clr", hb.data_read, 8'h00);
`else
    chk("t12_fwd_data3", hb.data_read, 8'hC3);
`endif
    tick1(); hb.read = 1'b0;

    // reset mid-ramp returns to IDLE at once, no further writes
    clear_logs();
    push_pair(16'h0010);
    start_ramp(16'h0010, 16'h0040, 16'h0010, 8'd0);
    tick1(); tick1();
    rst_n = 1'b0;
    #1;
    chk("t13_busy", ramp_busy, 1'b0);
    chk("t13_write", rb.write, 1'b0);
    tick1(); rst_n = 1'b1;
    repeat (30) tick1();
    lit = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_log("t13_log", lit, 2);
    chk("t13_done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
